inst_fetch_queue: RTL and testbench

Instruction buffer between the fetch stage and the decode stage. Captures each fetched {pc, instruction, predicted-taken} triple into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake. Decode-side stalls are absorbed without immediately freezing the PC. A branch-resolution flush discards every buffered wrong-path instruction in one cycle.

---
 rtl/inst_fetch_queue.sv | 82 ++++++++
 tb/tb_inst_fetch_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode instruction buffer: circular FIFO of {pred_taken, pc, inst}
// with valid/ready handshakes on both sides and a single-cycle flush.
module inst_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    input  logic                       in_pred_taken,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic                       out_pred_taken,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [64:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_push;
    logic           w_pop;
    logic [64:0]    w_head;

    // in_ready looks only at the stored count, keeping decode stalls off the PC-write path
    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign level     = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never cleared; only pointers and count define what is live
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= {in_pred_taken, in_pc, in_inst};
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        out_pred_taken = 1'b0;
        out_pc         = 32'h0;
        out_inst       = NOP_INST;
        if (out_valid) begin
            out_pred_taken = w_head[64];
            out_pc         = w_head[63:32];
            out_inst       = w_head[31:0];
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_pred_taken;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred_taken;
    logic        out_ready;
    logic [$clog2(DEPTH):0] level;

    int checks   = 0;
    int failures = 0;

    logic [64:0] exp_q[$];

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .in_pred_taken  (in_pred_taken),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_pred_taken (out_pred_taken),
        .out_ready      (out_ready),
        .level          (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs to the model each cycle and retires popped entries
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_level", 32'(level), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_inst", out_inst, NOP_INST);
            exp_q.delete();
        end else begin
            chk("level", 32'(level), 32'(exp_q.size()));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() == 0) begin
                chk("empty_pc", out_pc, 32'h0);
                chk("empty_inst", out_inst, NOP_INST);
                chk("empty_pred", 32'(out_pred_taken), 32'd0);
            end else begin
                chk("head_pc", out_pc, exp_q[0][63:32]);
                chk("head_inst", out_inst, exp_q[0][31:0]);
                chk("head_pred", 32'(out_pred_taken), 32'(exp_q[0][64]));
            end
            if (flush) exp_q.delete();
            else if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        end
    end

    // One clock of stimulus; called just after a rising edge, returns just after the next
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic pred, input logic ordy, input logic fl, output logic acc);
        in_valid      = v;
        in_pc         = pc;
        in_inst       = inst;
        in_pred_taken = pred;
        out_ready     = ordy;
        flush         = fl;
        acc = v && !fl && (exp_q.size() != DEPTH);
        @(posedge clk);
        if (acc) exp_q.push_back({pred, pc, inst});
        #1;
    endtask

    initial begin
        logic acc;
        logic done;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        in_pred_taken = 1'b0; out_ready = 1'b0;
        #1;
        chk("init_out_inst", out_inst, NOP_INST);
        chk("init_level", 32'(level), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;

        // Fill with decode stalled
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), $urandom, 1'(i & 1), 1'b0, 1'b0, acc);
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_out_pc", out_pc, 32'h0);

        // Drain in order
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        chk("drain_level", 32'(level), 32'd0);

        // Streaming through the wrap point
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h100 + 32'(i * 4), $urandom, $urandom_range(0, 1), 1'b1, 1'b0, acc);
        chk("stream_level", 32'(level), 32'd1);

        // Top up to full, then offer 0x10 with a simultaneous pop
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0, acc);
        chk("full_level", 32'(level), 32'd4);
        cyc(1'b1, 32'h10, 32'hABCD_0010, 1'b1, 1'b1, 1'b0, acc);
        chk("fullpop_level", 32'(level), 32'd3);
        chk("fullpop_in_ready", 32'(in_ready), 32'd1);
        done = 1'b0;
        for (int t = 0; t < 8 && !done; t++) begin
            cyc(1'b1, 32'h10, 32'hABCD_0010, 1'b1, 1'b0, 1'b0, acc);
            done = acc;
        end
        chk("retry_accepted", 32'(done), 32'd1);
        chk("retry_level", 32'(level), 32'd4);

        // Flush at level 3 together with a push and a pop
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        chk("preflush_level", 32'(level), 32'd3);
        cyc(1'b1, 32'h40, 32'hDEAD_0040, 1'b1, 1'b1, 1'b1, acc);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        cyc(1'b1, 32'h80, 32'hBEEF_0080, 1'b1, 1'b0, 1'b0, acc);
        chk("post_flush_pc", out_pc, 32'h80);
        chk("post_flush_pred", 32'(out_pred_taken), 32'd1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, acc);

        // Asynchronous reset between edges at level 2
        cyc(1'b1, 32'h300, $urandom, 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, 32'h304, $urandom, 1'b1, 1'b0, 1'b0, acc);
        chk("prereset_level", 32'(level), 32'd2);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_level", 32'(level), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_out_inst", out_inst, NOP_INST);
        exp_q.delete();
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0), acc);
        end
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
